// File: rtl/ervp_fifo_write_arbiter_if.sv
// Write-side bundle between NUM_REQ producers, the arbiter and a single FIFO write port.
// slave = arbiter view, master = producer/FIFO side view.
interface ervp_fifo_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int BW_DATA = 32
);
  logic [NUM_REQ-1:0]         req_wrequest;
  logic [NUM_REQ*BW_DATA-1:0] req_wdata;
  logic [NUM_REQ-1:0]         req_wlast;
  logic [NUM_REQ-1:0]         req_wready;
  logic                       fifo_wready;
  logic                       fifo_wrequest;
  logic [BW_DATA-1:0]         fifo_wdata;

  modport slave (
    input  req_wrequest, req_wdata, req_wlast, fifo_wready,
    output req_wready, fifo_wrequest, fifo_wdata
  );

  modport master (
    output req_wrequest, req_wdata, req_wlast, fifo_wready,
    input  req_wready, fifo_wrequest, fifo_wdata
  );
endinterface

// File: rtl/ervp_fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, with registered
// grant, optional packet lock (wlast) or per-grant beat cap.
module ervp_fifo_write_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int BW_DATA     = 32,
  parameter int LOCK_PACKET = 1,
  parameter int MAX_BURST   = 16,
  parameter int BW_ID       = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      clear,
  ervp_fifo_write_arbiter_if.slave  wport,
  output logic                      grant_valid,
  output logic [BW_ID-1:0]          grant_id
);

  localparam int               BW_CNT    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW_CNT-1:0] CNT_LIMIT = BW_CNT'(MAX_BURST - 1);
  localparam logic [BW_ID-1:0]  LAST_INIT = BW_ID'(NUM_REQ - 1);

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t              state, state_n;
  logic [BW_ID-1:0]    grant_id_n;
  logic [BW_ID-1:0]    last, last_n;
  logic [BW_CNT-1:0]   beat_cnt, beat_cnt_n;

  logic                go, cur_req, cur_last, burst_end, accept, rel;
  logic [NUM_REQ-1:0]  ready;
  logic [NUM_REQ-1:0]  cand;
  logic [BW_ID-1:0]    base, winner;
  logic                found;

  // One search serves both cases: from last in IDLE, and from the current
  // holder (itself masked) when re-arbitrating at release.
  always_comb begin
    int unsigned pos;
    logic [BW_ID-1:0] pos_id;
    cand   = wport.req_wrequest;
    base   = last;
    found  = 1'b0;
    winner = '0;
    pos    = 0;
    pos_id = '0;
    if (state == GRANTED) begin
      cand[grant_id] = 1'b0;
      base           = grant_id;
    end
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      pos    = (32'(base) + k) % NUM_REQ;
      pos_id = pos[BW_ID-1:0];
      if (!found && cand[pos_id]) begin
        found  = 1'b1;
        winner = pos_id;
      end
    end
  end

  always_comb begin
    go        = enable & ~clear;
    cur_req   = wport.req_wrequest[grant_id];
    cur_last  = wport.req_wlast[grant_id];
    burst_end = (beat_cnt == CNT_LIMIT);
    ready     = '0;
    if (state == GRANTED && go && wport.fifo_wready) ready[grant_id] = 1'b1;
    accept    = ready[grant_id] & cur_req;
    if (LOCK_PACKET != 0) rel = accept & cur_last;
    else                  rel = (accept & (cur_last | burst_end)) | ~cur_req;

    state_n    = state;
    grant_id_n = grant_id;
    last_n     = last;
    beat_cnt_n = beat_cnt;
    if (enable) begin
      if (clear) begin
        state_n    = IDLE;
        grant_id_n = '0;
        last_n     = LAST_INIT;
        beat_cnt_n = '0;
      end else if (state == IDLE) begin
        if (found) begin
          state_n    = GRANTED;
          grant_id_n = winner;
          beat_cnt_n = '0;
        end
      end else if (rel) begin
        last_n     = grant_id;
        beat_cnt_n = '0;
        if (found) grant_id_n = winner;
        else       state_n    = IDLE;
      end else if (accept) begin
        beat_cnt_n = beat_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant_id <= '0;
      last     <= LAST_INIT;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      grant_id <= grant_id_n;
      last     <= last_n;
      beat_cnt <= beat_cnt_n;
    end
  end

  assign grant_valid         = (state == GRANTED);
  assign wport.req_wready    = ready;
  assign wport.fifo_wrequest = accept;
  assign wport.fifo_wdata    = wport.req_wdata[BW_DATA*grant_id +: BW_DATA];

endmodule

// File: tb/tb_ervp_fifo_write_arbiter.sv
// Bench for ervp_fifo_write_arbiter: a packet-locked instance and a burst-capped instance
// share the same stimulus and are both checked every cycle against a rule-level model.
module tb_ervp_fifo_write_arbiter;
  localparam int NR = 4, BW = 16, MB_A = 16, MB_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, enable, clear, fready;
  logic [NR-1:0]      req, wlast;
  logic [NR*BW-1:0]   wdata;
  logic               gv_a, gv_b;
  logic [1:0]         gid_a, gid_b;

  ervp_fifo_write_arbiter_if #(.NUM_REQ(NR), .BW_DATA(BW)) if_a ();
  ervp_fifo_write_arbiter_if #(.NUM_REQ(NR), .BW_DATA(BW)) if_b ();

  assign if_a.req_wrequest = req;   assign if_b.req_wrequest = req;
  assign if_a.req_wdata    = wdata; assign if_b.req_wdata    = wdata;
  assign if_a.req_wlast    = wlast; assign if_b.req_wlast    = wlast;
  assign if_a.fifo_wready  = fready; assign if_b.fifo_wready = fready;

  ervp_fifo_write_arbiter #(.NUM_REQ(NR), .BW_DATA(BW), .LOCK_PACKET(1), .MAX_BURST(MB_A)) dut_a (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .wport(if_a.slave),
    .grant_valid(gv_a), .grant_id(gid_a));
  ervp_fifo_write_arbiter #(.NUM_REQ(NR), .BW_DATA(BW), .LOCK_PACKET(0), .MAX_BURST(MB_B)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .wport(if_b.slave),
    .grant_valid(gv_b), .grant_id(gid_b));

  int checks = 0, failures = 0;

  // reference model state, index 0 = packet lock, 1 = burst cap
  int m_gv[2], m_gid[2], m_last[2], m_beats[2];
  int lockm[2] = '{1, 0};
  int mb[2]    = '{MB_A, MB_B};

  // producer behaviour for directed sequences
  int pact[NR], plen[NR], pbeat[NR];
  int follow = -1;
  logic [NR-1:0] acc_a, acc_b;
  int acc_q_a[$], acc_q_b[$];

  typedef struct {
    logic rst; logic [NR-1:0] req; logic [NR-1:0] wlast; logic fr;
    logic gv; logic [1:0] gid; logic [NR-1:0] rdy; logic fwreq;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int rr_winner(input logic [NR-1:0] cand, input int after);
    for (int off = 1; off <= NR; off++) begin
      int idx;
      idx = (after + off) % NR;
      if (cand[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset(input int m);
    m_gv[m] = 0; m_gid[m] = 0; m_last[m] = NR - 1; m_beats[m] = 0;
  endtask

  task automatic model_edge(input int m);
    int w, g;
    bit acc, done;
    g = m_gid[m];
    if (rst) model_reset(m);
    else if (enable) begin
      if (clear) model_reset(m);
      else if (m_gv[m] == 0) begin
        w = rr_winner(req, m_last[m]);
        if (w >= 0) begin m_gv[m] = 1; m_gid[m] = w; m_beats[m] = 0; end
      end else begin
        acc = fready && req[g];
        if (lockm[m] != 0) done = acc && wlast[g];
        else done = (acc && (wlast[g] || m_beats[m] + 1 == mb[m])) || !req[g];
        if (acc) m_beats[m]++;
        if (done) begin
          m_last[m] = g; m_beats[m] = 0;
          w = rr_winner(req & ~(NR'(1) << g), g);
          if (w >= 0) m_gid[m] = w; else m_gv[m] = 0;
        end
      end
    end
  endtask

  task automatic check_dut(input int m, input string tag);
    logic [NR-1:0] er, ar;
    logic ef, af, agv;
    logic [BW-1:0] ed, ad;
    logic [1:0] agid;
    string s;
    er = '0;
    if (m_gv[m] != 0 && enable && !clear && fready) er[m_gid[m]] = 1'b1;
    ef = |(er & req);
    ed = wdata[BW*m_gid[m] +: BW];
    if (m == 0) begin ar = if_a.req_wready; af = if_a.fifo_wrequest; ad = if_a.fifo_wdata; agv = gv_a; agid = gid_a; end
    else        begin ar = if_b.req_wready; af = if_b.fifo_wrequest; ad = if_b.fifo_wdata; agv = gv_b; agid = gid_b; end
    s = (m == 0) ? "a" : "b";
    chk($sformatf("%s_%s_grant_valid", tag, s), agv, m_gv[m]);
    chk($sformatf("%s_%s_grant_id", tag, s), agid, m_gid[m]);
    chk($sformatf("%s_%s_req_wready", tag, s), ar, er);
    chk($sformatf("%s_%s_fifo_wrequest", tag, s), af, ef);
    chk($sformatf("%s_%s_fifo_wdata", tag, s), ad, ed);
  endtask

  task automatic drive_producers();
    for (int i = 0; i < NR; i++) begin
      req[i]   = (pact[i] != 0);
      wlast[i] = (pbeat[i] == plen[i] - 1);
      wdata[BW*i +: BW] = BW'((i << 8) | (pbeat[i] & 255));
    end
  endtask

  task automatic step_check(input string tag);
    @(negedge clk);
    check_dut(0, tag);
    check_dut(1, tag);
    acc_a = if_a.req_wready & req;
    acc_b = if_b.req_wready & req;
    for (int i = 0; i < NR; i++) begin
      if (acc_a[i]) acc_q_a.push_back(i);
      if (acc_b[i]) acc_q_b.push_back(i);
    end
  endtask

  task automatic step_edge();
    logic [NR-1:0] acc;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    if (follow >= 0) begin
      acc = (follow == 0) ? acc_a : acc_b;
      for (int i = 0; i < NR; i++)
        if (acc[i]) pbeat[i] = (pbeat[i] >= plen[i] - 1) ? 0 : pbeat[i] + 1;
    end
    #1;
  endtask

  task automatic pstep(input string tag);
    drive_producers();
    step_check(tag);
    step_edge();
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b1; clear = 1'b0; fready = 1'b1; follow = -1;
    for (int i = 0; i < NR; i++) begin pact[i] = 0; pbeat[i] = 0; plen[i] = 4; end
    pstep("rst");
    rst = 1'b0;
    acc_q_a.delete(); acc_q_b.delete();
  endtask

  initial begin
    int cnt, stall, saved_gid;
    tbl[0]  = '{1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0};
    tbl[1]  = '{1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0};
    tbl[2]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 4'h0, 1'b0};
    tbl[3]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 2'd0, 4'h1, 1'b1};
    tbl[4]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 2'd1, 4'h2, 1'b1};
    tbl[5]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 2'd2, 4'h4, 1'b1};
    tbl[6]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 2'd3, 4'h8, 1'b1};
    tbl[7]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b1, 2'd0, 4'h1, 1'b1};
    tbl[8]  = '{1'b0, 4'hF, 4'hF, 1'b0, 1'b1, 2'd1, 4'h0, 1'b0};
    tbl[9]  = '{1'b0, 4'h2, 4'h2, 1'b1, 1'b1, 2'd1, 4'h2, 1'b1};
    tbl[10] = '{1'b0, 4'h2, 4'h2, 1'b1, 1'b0, 2'd1, 4'h0, 1'b0};
    tbl[11] = '{1'b0, 4'h2, 4'h2, 1'b1, 1'b1, 2'd1, 4'h2, 1'b1};

    rst = 1'b1; enable = 1'b1; clear = 1'b0; fready = 1'b1; req = '0; wlast = '0;
    for (int i = 0; i < NR; i++) wdata[BW*i +: BW] = BW'(16'hA000 + i);
    model_reset(0); model_reset(1);
    repeat (2) @(posedge clk);
    #1;

    // reset behaviour and plain round robin with single-beat packets
    for (int r = 0; r < 12; r++) begin
      rst = tbl[r].rst; req = tbl[r].req; wlast = tbl[r].wlast; fready = tbl[r].fr;
      step_check("tbl");
      chk($sformatf("tbl%0d_a_gv", r), gv_a, tbl[r].gv);
      chk($sformatf("tbl%0d_a_gid", r), gid_a, tbl[r].gid);
      chk($sformatf("tbl%0d_a_rdy", r), if_a.req_wready, tbl[r].rdy);
      chk($sformatf("tbl%0d_a_fwreq", r), if_a.fifo_wrequest, tbl[r].fwreq);
      chk($sformatf("tbl%0d_b_gid", r), gid_b, tbl[r].gid);
      chk($sformatf("tbl%0d_b_rdy", r), if_b.req_wready, tbl[r].rdy);
      step_edge();
    end

    // fairness: four producers of 3-beat packets, no bubble between grants
    do_reset();
    follow = 0;
    for (int i = 0; i < NR; i++) begin pact[i] = 1; plen[i] = 3; end
    repeat (16) pstep("rr");
    chk("rr_accept_count", acc_q_a.size(), 15);
    for (int k = 0; k < 15; k++)
      if (k < acc_q_a.size()) chk($sformatf("rr_order%0d", k), acc_q_a[k], (k / 3) % 4);

    // packet lock survives backpressure
    do_reset();
    follow = 0; pact[1] = 1; plen[1] = 4; plen[2] = 4;
    pstep("lock");
    pact[2] = 1; cnt = 0; stall = 0;
    for (int t = 0; t < 30 && cnt < 4; t++) begin
      fready = !(cnt == 2 && stall < 5);
      if (!fready) stall++;
      drive_producers();
      step_check("lock");
      chk("lock_gid_held", gid_a, 2'd1);
      if (if_a.fifo_wrequest) chk("lock_wdata_src", if_a.fifo_wdata[15:8], 8'd1);
      step_edge();
      cnt = acc_q_a.size();
    end
    chk("lock_packet_done", cnt, 4);
    chk("lock_stall_cycles", stall, 5);
    fready = 1'b1;
    drive_producers();
    step_check("lock");
    chk("lock_next_gid", gid_a, 2'd2);
    step_edge();

    // burst cap: 0 and 3 stream without wlast
    do_reset();
    follow = 1; pact[0] = 1; pact[3] = 1; plen[0] = 1000; plen[3] = 1000;
    repeat (13) pstep("burst");
    chk("burst_accept_count", acc_q_b.size(), 12);
    for (int k = 0; k < 12; k++)
      if (k < acc_q_b.size()) chk($sformatf("burst_order%0d", k), acc_q_b[k], ((k / 4) % 2 == 0) ? 0 : 3);

    // drop release
    do_reset();
    follow = 1; pact[2] = 1; plen[2] = 1000; plen[0] = 1000;
    pstep("drop");
    pact[0] = 1;
    pstep("drop");
    pact[2] = 0;
    pstep("drop");
    drive_producers();
    step_check("drop");
    chk("drop_gid", gid_b, 2'd0);
    chk("drop_gv", gv_b, 1'b1);
    step_edge();
    pact[0] = 0;
    pstep("drop");
    drive_producers();
    step_check("drop");
    chk("drop_idle_gv", gv_b, 1'b0);
    step_edge();

    // clear mid-packet, then enable gap mid-grant
    do_reset();
    follow = 0; pact[1] = 1;
    repeat (3) pstep("clr");
    clear = 1'b1;
    drive_producers();
    step_check("clr");
    chk("clr_rdy_quiet", if_a.req_wready, 4'h0);
    chk("clr_fwreq_quiet", if_a.fifo_wrequest, 1'b0);
    step_edge();
    clear = 1'b0;
    for (int i = 0; i < NR; i++) pact[i] = 1;
    drive_producers();
    step_check("clr");
    chk("clr_gv", gv_a, 1'b0);
    step_edge();
    drive_producers();
    step_check("clr");
    chk("clr_last_reset", gid_a, 2'd0);
    step_edge();
    pstep("gap");
    saved_gid = gid_a;
    enable = 1'b0;
    repeat (3) begin
      drive_producers();
      step_check("gap");
      chk("gap_rdy_a", if_a.req_wready, 4'h0);
      chk("gap_rdy_b", if_b.req_wready, 4'h0);
      chk("gap_gid", gid_a, saved_gid);
      step_edge();
    end
    enable = 1'b1;
    drive_producers();
    step_check("gap");
    chk("gap_resume", if_a.fifo_wrequest, 1'b1);
    step_edge();
    repeat (6) pstep("gap");

    // randomized traffic, both instances against the model
    follow = -1;
    for (int t = 0; t < 3000; t++) begin
      rst    = ($urandom_range(0, 199) == 0);
      enable = ($urandom_range(0, 15) != 0);
      clear  = ($urandom_range(0, 63) == 0);
      fready = ($urandom_range(0, 3) != 0);
      req    = NR'($urandom) | NR'($urandom);
      wlast  = NR'($urandom) & NR'($urandom);
      wdata  = {$urandom(), $urandom()};
      step_check("rnd");
      step_edge();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ervp_fifo_write_arbiter.md
Name: ervp_fifo_write_arbiter

Overview:
- Shares the write port of one small FIFO among NUM_REQ producers.
- Round-robin arbitration; grant is registered, so a decision appears one edge after the requests are sampled.
- Optionally locks the grant until a whole packet (ending with wlast) has been written, or caps each grant at MAX_BURST beats.
- Sits between producer channels and the FIFO wready/wrequest/wdata port.

Parameters:
- NUM_REQ, 4, number of producers (>=2).
- BW_DATA, 32, data width per producer.
- LOCK_PACKET, 1: 1 = hold grant until the wlast beat is accepted; 0 = release on wlast, on MAX_BURST beats, or when the granted requester drops wrequest.
- MAX_BURST, 16, beat cap per grant when LOCK_PACKET=0 (>=1).
- BW_ID, $clog2(NUM_REQ), width of grant_id.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  0 = freeze all state; all readies and fifo_wrequest forced to 0.
- clear  in  1  synchronous soft reset, same effect as rst.
- req_wrequest  in  NUM_REQ  per-producer write request.
- req_wdata  in  NUM_REQ*BW_DATA  producer i data in bits [BW_DATA*(i+1)-1 -: BW_DATA].
- req_wlast  in  NUM_REQ  last beat of packet.
- req_wready  out  NUM_REQ  per-producer accept; one-hot or zero.
- fifo_wready  in  1  FIFO has space.
- fifo_wrequest  out  1  write strobe to the FIFO.
- fifo_wdata  out  BW_DATA  data to the FIFO.
- grant_valid  out  1  a producer currently holds the grant.
- grant_id  out  BW_ID  index of the current or last granted producer.

Behaviour:
- Reset values (rst=1 at edge): grant_valid=0, grant_id=0, rr pointer last=NUM_REQ-1, beat_cnt=0. Consequently req_wready=0 and fifo_wrequest=0.
- clear=1 (with enable): identical to rst. Outputs req_wready and fifo_wrequest are also 0 combinationally during that cycle.
- States: IDLE (grant_valid=0) and GRANTED (grant_valid=1).
- Arbitration function: the first set bit of the candidate vector, searching from index last+1 upward with wrap.
- IDLE: if enable and any req_wrequest, then at the edge grant_valid<=1, grant_id<=winner, beat_cnt<=0. Otherwise stay in IDLE.
- GRANTED, g=grant_id:
  - req_wready[g] = enable & ~clear & fifo_wready; all other bits are 0.
  - fifo_wrequest = accept = req_wready[g] & req_wrequest[g].
  - fifo_wdata = slice g of req_wdata, always, regardless of state.
- Release condition in GRANTED:
  - LOCK_PACKET=1: accept & req_wlast[g].
  - LOCK_PACKET=0: (accept & (req_wlast[g] | beat_cnt==MAX_BURST-1)) | ~req_wrequest[g].
- beat_cnt increments on each accept and is cleared on release or new grant. Width holds MAX_BURST-1.
- On release: last<=g, and re-arbitration happens at the same edge over req_wrequest with bit g masked.
  - If there is a winner: stay GRANTED with the new grant_id; no bubble.
  - If there is none: go to IDLE. The released producer can be re-granted from IDLE on the next cycle.
- FIFO full (fifo_wready=0): no accept. Grant and beat_cnt are held; lock is never broken by backpressure.
- enable=0: all registers hold and outputs are quiet. A grant survives an enable gap.
- Producers must keep wdata/wlast stable while wrequest=1 and wready=0. The arbiter does not buffer data.
- Simultaneous clear and release: clear wins.
- Single requester: throughput is one packet per (packet length + 1) cycles, because of the IDLE bubble; the bubble is accepted.
- Latency: first beat is accepted no earlier than 1 cycle after wrequest rises from IDLE.

Test Plan:
1. Reset/idle: rst=1 with all requests high for 2 cycles, then deassert rst -> during reset grant_valid=0, req_wready=0, fifo_wrequest=0; the cycle after deassert grant_id=0, grant_valid=1.
2. Round-robin fairness, LOCK_PACKET=1, NUM_REQ=4: all 4 requesters send continuous 3-beat packets with fifo_wready=1 -> grant order 0,1,2,3,0, with 3 accepts per grant and no idle cycle between grants.
3. Packet lock under backpressure: producer 1 granted, 4-beat packet, fifo_wready low for 5 cycles after beat 2, producer 2 requesting -> grant_id stays 1 until beat 4 (wlast) is accepted; fifo_wdata never sourced from producer 2 mid-packet.
4. Burst cap, LOCK_PACKET=0, MAX_BURST=4: producers 0 and 3 stream without wlast -> grant alternates 0,3,0 every 4 accepts; beat_cnt wraps to 0 at each switch.
5. Drop release, LOCK_PACKET=0: producer 2 granted and lowers wrequest after 1 beat while producer 0 requests -> next edge grant_id=0; if no other requester, grant_valid=0.
6. clear mid-packet plus enable gap: assert clear at beat 2 of a locked packet -> next cycle grant_valid=0 and last=NUM_REQ-1. Separately, enable=0 for 3 cycles mid-grant -> all readies 0, grant_id and beat_cnt unchanged, streaming resumes afterwards.
